// File: rtl/snake_pkg.sv
// Shared types for the snake game controller: grid coordinates, move
// directions and controller states.
package snake_pkg;

    localparam int GRID_DIM = 8;

    typedef struct packed {
        logic [2:0] y;
        logic [2:0] x;
    } vec2_t;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        NEXT   = 3'd1,
        CHECK  = 3'd2,
        COMMIT = 3'd3,
        OVER   = 3'd4
    } state_t;

    // Opposite directions differ only in bit 1 (UP/DOWN, RIGHT/LEFT).
    function automatic logic is_opposite(input dir_t a, input dir_t b);
        return (a ^ b) == 2'd2;
    endfunction

endpackage

// File: rtl/snake_body_fifo.sv
// Circular buffer holding the snake body cells, oldest (tail) to newest
// (head). Comes out of reset holding the single cell {0,0}.
module snake_body_fifo
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_head,
    input  vec2_t      head_in,
    input  logic       pop_tail,
    output vec2_t      tail,
    output logic [6:0] count
);

    localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    vec2_t         mem [MAX_LEN];
    logic [PW-1:0] hd;
    logic [PW-1:0] tl;
    logic [PW-1:0] hd_inc;
    logic [PW-1:0] tl_inc;

    assign hd_inc = (hd == PW'(MAX_LEN - 1)) ? '0 : hd + 1'b1;
    assign tl_inc = (tl == PW'(MAX_LEN - 1)) ? '0 : tl + 1'b1;
    assign tail   = mem[tl];

    // Push writes the slot after the current head; pop advances the tail.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < MAX_LEN; i++) mem[i] <= '0;
            hd    <= '0;
            tl    <= '0;
            count <= 7'd1;
        end else begin
            if (push_head) begin
                mem[hd_inc] <= head_in;
                hd          <= hd_inc;
            end
            if (pop_tail) tl <= tl_inc;
            count <= count + 7'(push_head) - 7'(pop_tail);
        end
    end

endmodule

// File: rtl/snake_ctrl.sv
// Snake game step controller on an 8x8 grid.
// Each accepted tick runs NEXT -> CHECK -> COMMIT; a collision ends in OVER,
// which only reset leaves. Define SNAKE_WRAP_EN to make the grid edges wrap
// instead of acting as walls.
module snake_ctrl
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       dir_valid,
    input  logic [1:0] dir,
    input  logic       food_valid,
    input  logic [5:0] food_pos,
    output logic       food_ack,
    input  logic [2:0] rd_row,
    output logic [7:0] rd_data,
    output logic [5:0] head_pos,
    output logic [6:0] length,
    output logic       busy,
    output logic       ate,
    output logic       game_over
);

    localparam logic [GRID_DIM-1:0][GRID_DIM-1:0] GRID_RESET = 64'h01;

    state_t state;
    dir_t   dir_cur;
    dir_t   dir_pend;
    vec2_t  head;
    vec2_t  nh;
    vec2_t  food;
    vec2_t  fp;
    vec2_t  tail;
    logic   has_food;
    logic   wall;
    logic   eat;
    logic   grow;

    logic [GRID_DIM-1:0][GRID_DIM-1:0] grid_q;
    logic [GRID_DIM-1:0][GRID_DIM-1:0] grid_d;

    logic [3:0] cx;
    logic [3:0] cy;
    vec2_t      nh_c;
    logic       wall_c;
    logic       eat_c;
    logic       grow_c;
    logic       coll_c;
    logic       food_ok;
    logic [6:0] count;

    assign fp       = food_pos;
    assign head_pos = head;
    assign length   = count;

    snake_body_fifo #(.MAX_LEN(MAX_LEN)) u_body (
        .clk       (clk),
        .reset     (reset),
        .push_head (state == COMMIT),
        .head_in   (nh),
        .pop_tail  ((state == COMMIT) && !grow),
        .tail      (tail),
        .count     (count)
    );

    // Candidate head: one extra bit per axis flags leaving the grid.
    always_comb begin
        cx = {1'b0, head.x};
        cy = {1'b0, head.y};
        case (dir_cur)
            UP:      cy = cy - 4'd1;
            RIGHT:   cx = cx + 4'd1;
            DOWN:    cy = cy + 4'd1;
            default: cx = cx - 4'd1;
        endcase
        nh_c = '{y: cy[2:0], x: cx[2:0]};
`ifdef SNAKE_WRAP_EN
        wall_c = 1'b0;
`else
        wall_c = cx[3] | cy[3];
`endif
    end

    // Collision / food evaluation on the registered candidate head.
    // The tail cell is free to enter unless this step grows the snake.
    always_comb begin
        eat_c  = has_food && (nh == food);
        grow_c = eat_c && (count < 7'(MAX_LEN));
        coll_c = wall || (grid_q[nh.y][nh.x] && !((nh == tail) && !grow_c));
    end

    // Grid update: tail clear then head set, so a head moving into the
    // vacating tail cell stays marked.
    always_comb begin
        grid_d = grid_q;
        if (state == COMMIT) begin
            if (!grow) grid_d[tail.y][tail.x] = 1'b0;
            grid_d[nh.y][nh.x] = 1'b1;
        end
    end

    // Food may only be placed on a free cell while idle with no food out.
    always_comb begin
        food_ok = (state == IDLE) && food_valid && !has_food && !grid_q[fp.y][fp.x];
    end

    // Step FSM with registered status outputs, grid and readout.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            head      <= '0;
            nh        <= '0;
            food      <= '0;
            wall      <= 1'b0;
            eat       <= 1'b0;
            grow      <= 1'b0;
            dir_cur   <= RIGHT;
            dir_pend  <= RIGHT;
            has_food  <= 1'b0;
            busy      <= 1'b0;
            ate       <= 1'b0;
            food_ack  <= 1'b0;
            game_over <= 1'b0;
            grid_q    <= GRID_RESET;
            rd_data   <= GRID_RESET[rd_row];
        end else begin
            ate      <= 1'b0;
            food_ack <= 1'b0;
            grid_q   <= grid_d;
            rd_data  <= grid_d[rd_row];

            if (dir_valid && state != OVER) dir_pend <= dir_t'(dir);

            if (food_ok) begin
                has_food <= 1'b1;
                food     <= fp;
                food_ack <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= NEXT;
                        busy  <= 1'b1;
                        if (!is_opposite(dir_pend, dir_cur)) dir_cur <= dir_pend;
                    end
                end
                NEXT: begin
                    nh    <= nh_c;
                    wall  <= wall_c;
                    state <= CHECK;
                end
                CHECK: begin
                    eat  <= eat_c;
                    grow <= grow_c;
                    if (coll_c) begin
                        state     <= OVER;
                        busy      <= 1'b0;
                        game_over <= 1'b1;
                    end else begin
                        state <= COMMIT;
                        ate   <= eat_c;
                    end
                end
                COMMIT: begin
                    head  <= nh;
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (eat) has_food <= 1'b0;
                end
                OVER: begin
                    state <= OVER;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
